// File: rtl/fb_write_arbiter.sv
// Per-frame framebuffer write-port scheduler: grants requesters one at a time in
// index order, forwards the owner's pixels with one registered stage, then requests a swap.
module fb_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int XW    = 10,
  parameter int DW    = 8,
  parameter int TMO   = 20000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [1:0]          frame_clk_edge,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    done,
  input  logic [N_REQ-1:0]    wr_valid_in,
  input  logic [N_REQ*XW-1:0] wr_x_in,
  input  logic [N_REQ*XW-1:0] wr_y_in,
  input  logic [N_REQ*DW-1:0] wr_color_in,
  output logic [N_REQ-1:0]    grant,
  output logic [XW-1:0]       draw_x,
  output logic [XW-1:0]       draw_y,
  output logic [DW-1:0]       draw_color,
  output logic                wr_en,
  output logic                swap,
  output logic                busy,
  output logic                overrun,
  output logic                timeout
);

  localparam int IW = $clog2(N_REQ + 1);
  localparam int CW = $clog2(TMO + 1);

  // state   | meaning
  // S_IDLE  | waiting for frame start
  // S_SCAN  | testing req[idx], one index per cycle
  // S_GRANT | requester idx owns the write port
  // S_SWAP  | one-cycle buffer swap request
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GRANT, S_SWAP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [XW-1:0]     draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic [DW-1:0]     draw_color_q, draw_color_d;
  logic              wr_en_q, wr_en_d, overrun_q, overrun_d, timeout_q, timeout_d;

  logic              frame_start, tmo_hit;
  logic              sel_req, sel_done, sel_valid;
  logic [XW-1:0]     sel_x, sel_y;
  logic [DW-1:0]     sel_color;

  assign frame_start = (frame_clk_edge == 2'b01);
  assign tmo_hit     = (cnt_q == CW'(TMO - 1));

  // idx can equal N_REQ, so select by compare instead of a direct index
  always_comb begin
    sel_req   = 1'b0;
    sel_done  = 1'b0;
    sel_valid = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx_q == IW'(i)) begin
        sel_req   = req[i];
        sel_done  = done[i];
        sel_valid = wr_valid_in[i];
        sel_x     = wr_x_in[i*XW +: XW];
        sel_y     = wr_y_in[i*XW +: XW];
        sel_color = wr_color_in[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    draw_x_d     = draw_x_q;
    draw_y_d     = draw_y_q;
    draw_color_d = draw_color_q;
    wr_en_d      = 1'b0;
    overrun_d    = frame_start && (state_q != S_IDLE);
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (idx_q == IW'(N_REQ)) begin
          state_d = S_SWAP;
        end else if (sel_req) begin
          state_d = S_GRANT;
          grant_d = N_REQ'(1) << idx_q;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_GRANT: begin
        wr_en_d = sel_valid;
        if (sel_valid) begin
          draw_x_d     = sel_x;
          draw_y_d     = sel_y;
          draw_color_d = sel_color;
        end
        if (sel_done || tmo_hit) begin
          state_d   = S_SCAN;
          grant_d   = '0;
          idx_d     = idx_q + IW'(1);
          timeout_d = !sel_done;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      draw_color_q <= '0;
      wr_en_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      draw_x_q     <= draw_x_d;
      draw_y_q     <= draw_y_d;
      draw_color_q <= draw_color_d;
      wr_en_q      <= wr_en_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant      = grant_q;
  assign draw_x     = draw_x_q;
  assign draw_y     = draw_y_q;
  assign draw_color = draw_color_q;
  assign wr_en      = wr_en_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != S_IDLE);
  assign swap       = (state_q == S_SWAP);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios plus random traffic, checked each
// cycle against a behavioural model of the frame schedule.
module tb_fb_write_arbiter;
  localparam int N   = 4;
  localparam int XW  = 10;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic            Clk, Reset;
  logic [1:0]      frame_clk_edge;
  logic [N-1:0]    req, done, wr_valid_in;
  logic [N*XW-1:0] wr_x_in, wr_y_in;
  logic [N*DW-1:0] wr_color_in;
  logic [N-1:0]    grant;
  logic [XW-1:0]   draw_x, draw_y;
  logic [DW-1:0]   draw_color;
  logic            wr_en, swap, busy, overrun, timeout;

  fb_write_arbiter #(.N_REQ(N), .XW(XW), .DW(DW), .TMO(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_edge(frame_clk_edge), .req(req), .done(done),
    .wr_valid_in(wr_valid_in), .wr_x_in(wr_x_in), .wr_y_in(wr_y_in),
    .wr_color_in(wr_color_in), .grant(grant), .draw_x(draw_x), .draw_y(draw_y),
    .draw_color(draw_color), .wr_en(wr_en), .swap(swap), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  bit seen99 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame walks positions 0..N; an owner keeps the port until done or TMO cycles
  bit          m_active = 0, m_swap = 0;
  int          m_pos = 0, m_owner = -1, m_cnt = 0;
  logic        e_wr_en = 0, e_overrun = 0, e_timeout = 0;
  logic [XW-1:0] e_x = 0, e_y = 0;
  logic [DW-1:0] e_c = 0;

  always @(posedge Clk) begin
    bit fs;
    e_wr_en = 0; e_overrun = 0; e_timeout = 0;
    if (Reset) begin
      m_active = 0; m_swap = 0; m_pos = 0; m_owner = -1; m_cnt = 0;
      e_x = 0; e_y = 0; e_c = 0;
    end else begin
      fs = (frame_clk_edge == 2'b01);
      if (m_active && fs) e_overrun = 1;
      if (!m_active) begin
        if (fs) begin m_active = 1; m_pos = 0; end
      end else if (m_swap) begin
        m_active = 0; m_swap = 0;
      end else if (m_owner >= 0) begin
        if (wr_valid_in[m_owner]) begin
          e_wr_en = 1;
          e_x = wr_x_in[m_owner*XW +: XW];
          e_y = wr_y_in[m_owner*XW +: XW];
          e_c = wr_color_in[m_owner*DW +: DW];
        end
        if (done[m_owner]) begin
          m_owner = -1; m_pos++;
        end else if (m_cnt == TMO - 1) begin
          e_timeout = 1; m_owner = -1; m_pos++;
        end else m_cnt++;
      end else if (m_pos == N) m_swap = 1;
      else if (req[m_pos]) begin m_owner = m_pos; m_cnt = 0; end
      else m_pos++;
    end
  end

  logic [N-1:0] prev_grant = '0;
  always @(negedge Clk) begin
    logic [N-1:0] eg;
    if (chk_en) begin
      eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("grant", grant, eg);
      chk("wr_en", wr_en, e_wr_en);
      chk("draw_x", draw_x, e_x);
      chk("draw_y", draw_y, e_y);
      chk("draw_color", draw_color, e_c);
      chk("busy", busy, m_active);
      chk("swap", swap, m_swap);
      chk("overrun", overrun, e_overrun);
      chk("timeout", timeout, e_timeout);
      chk("grant_onehot", $onehot0(grant), 1);
      chk("wr_en_wo_grant", wr_en & (prev_grant == 0), 0);
      if (draw_x == 10'd99) seen99 = 1;
    end
    prev_grant = grant;
  end

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic set_pix(input int i, input bit v, input logic [XW-1:0] x,
                         input logic [XW-1:0] y, input logic [DW-1:0] c);
    wr_valid_in[i] = v;
    wr_x_in[i*XW +: XW] = x;
    wr_y_in[i*XW +: XW] = y;
    wr_color_in[i*DW +: DW] = c;
  endtask

  task automatic clear_inputs();
    frame_clk_edge = 2'b00; done = '0; wr_valid_in = '0;
    wr_x_in = '0; wr_y_in = '0; wr_color_in = '0;
  endtask

  task automatic wait_grant(input logic [N-1:0] g);
    int n = 0;
    while (grant !== g && n < 60) begin cyc(); n++; end
    chk("wait_grant", grant, g);
  endtask

  task automatic frame_start();
    frame_clk_edge = 2'b01;
    cyc();
    frame_clk_edge = 2'b00;
  endtask

  initial begin
    int n, sw;
    Reset = 1; req = '0; clear_inputs();
    cyc(); chk_en = 1;
    cyc();
    chk("reset_outputs", {grant, wr_en, swap, busy, overrun, timeout}, 0);
    chk("reset_draw", {draw_x, draw_y, draw_color}, 0);
    Reset = 0;
    cyc();

    // no requesters: full skip, swap 5 cycles after leaving IDLE
    frame_start();
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!swap && n < 20) begin cyc(); n++; end
    chk("swap_latency", n, 5);
    cyc();
    chk("busy_after_swap", busy, 0);
    repeat (3) cyc();

    // requesters 0 and 2; requester 1 drives x=99 but must never be forwarded
    req = 4'b0101;
    frame_start();
    wait_grant(4'b0001);
    set_pix(0, 1, 10'd3, 10'd4, 8'h1F);
    set_pix(1, 1, 10'd99, 10'd99, 8'hEE);
    frame_clk_edge = 2'b01;
    cyc();
    frame_clk_edge = 2'b00;
    chk("px0_wr_en", wr_en, 1);
    chk("px0_x", draw_x, 3);
    chk("px0_y", draw_y, 4);
    chk("px0_color", draw_color, 8'h1F);
    chk("overrun_pulse", overrun, 1);
    done[0] = 1;
    cyc();
    chk("grant_after_done", grant, 0);
    chk("px1_wr_en", wr_en, 1);
    chk("overrun_one_cycle", overrun, 0);
    clear_inputs();
    wait_grant(4'b0100);
    set_pix(2, 1, 10'd7, 10'd8, 8'h2A);
    set_pix(3, 1, 10'd99, 10'd1, 8'h55);
    done[2] = 1;
    cyc();
    clear_inputs();
    chk("px2_x", draw_x, 7);
    chk("px2_color", draw_color, 8'h2A);
    chk("px2_grant", grant, 0);
    sw = 0;
    repeat (30) begin if (swap) sw++; cyc(); end
    chk("single_swap", sw, 1);
    chk("idle_after_overrun", busy, 0);
    chk("never_x99", seen99, 0);

    // requester 1 never finishes: forced release after TMO cycles, then requester 2
    req = 4'b0110;
    frame_start();
    wait_grant(4'b0010);
    n = 1;
    do begin
      cyc();
      if (grant == 4'b0010) n++;
    end while (grant == 4'b0010 && n < 40);
    chk("tmo_cycles", n, 16);
    chk("timeout_pulse", timeout, 1);
    cyc();
    chk("grant_next", grant, 4'b0100);
    done[2] = 1;
    cyc();
    done = '0;
    repeat (10) cyc();

    // reset during a grant with a pixel pending
    req = 4'b0001;
    frame_start();
    wait_grant(4'b0001);
    set_pix(0, 1, 10'd11, 10'd12, 8'h33);
    cyc();
    Reset = 1;
    cyc();
    Reset = 0;
    clear_inputs();
    chk("rst_grant", grant, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap", swap, 0);
    sw = 0;
    repeat (20) begin if (swap) sw++; cyc(); end
    chk("no_swap_after_abort", sw, 0);

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      Reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) frame_clk_edge = 2'b01;
      else case ($urandom_range(0, 2))
        0: frame_clk_edge = 2'b00;
        1: frame_clk_edge = 2'b10;
        default: frame_clk_edge = 2'b11;
      endcase
      if ($urandom_range(0, 19) == 0) req = N'($urandom);
      done        = N'($urandom & $urandom & $urandom);
      wr_valid_in = N'($urandom);
      wr_x_in     = (N*XW)'({$urandom, $urandom});
      wr_y_in     = (N*XW)'({$urandom, $urandom});
      wr_color_in = (N*DW)'($urandom);
      cyc();
    end
    Reset = 0; clear_inputs();
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Per-frame scheduler that shares the single framebuffer write port (x, y, colour, write enable) among N drawing requesters, such as background clear, platforms, doodle and HUD.
- Sits between the drawing sub-engines and framebuffer2.
- On each frame start it grants requesters one at a time in fixed index order, forwards the granted requester's pixel writes with one cycle of registered latency, then pulses a buffer-swap request to the double-buffered framebuffer.

Parameters:
N_REQ, 4, number of requesters; index 0 is served first (background clear)
XW, 10, coordinate width for x and y
DW, 8, colour (palette index) width
TMO, 20000, maximum clock cycles a single grant may last before forced release

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
frame_clk_edge  in  2  sampled vblank history; 2'b01 marks frame start
req  in  N_REQ  requester i has work this frame; level, sampled at scan
done  in  N_REQ  requester i finished; honoured only while granted
wr_valid_in  in  N_REQ  requester i presents a pixel this cycle
wr_x_in  in  N_REQ*XW  packed x coordinates; requester i at [i*XW +: XW]
wr_y_in  in  N_REQ*XW  packed y coordinates, same packing as wr_x_in
wr_color_in  in  N_REQ*DW  packed colours; requester i at [i*DW +: DW]
grant  out  N_REQ  one-hot or zero; requester i owns the port
draw_x  out  XW  framebuffer write x
draw_y  out  XW  framebuffer write y
draw_color  out  DW  framebuffer write colour
wr_en  out  1  framebuffer write strobe
swap  out  1  one-cycle pulse: request buffer swap
busy  out  1  high while not IDLE
overrun  out  1  one-cycle pulse: frame start arrived while busy
timeout  out  1  one-cycle pulse: a grant was force-released

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is IDLE; idx = 0; timeout counter = 0.
- FSM states: IDLE, SCAN, GRANT, SWAP.
- IDLE:
  - On frame_clk_edge == 2'b01, go to SCAN with idx = 0.
  - busy goes high the next cycle.
- SCAN (1 cycle per index):
  - If idx == N_REQ, go to SWAP.
  - Else if req[idx] = 1, go to GRANT and set grant = one-hot(idx) on that transition.
  - Else increment idx and stay in SCAN.
  - A full skip of all N_REQ requesters costs N_REQ+1 cycles before SWAP.
- GRANT:
  - Each cycle, register the selected requester's inputs:
    - wr_en <= wr_valid_in[idx].
    - draw_x/draw_y/draw_color <= that requester's slice, but only when wr_valid_in[idx] = 1; otherwise they hold their values.
  - Latency from requester input to framebuffer outputs is exactly 1 cycle.
  - When done[idx] = 1:
    - A same-cycle pixel, if valid, is still forwarded.
    - grant clears the next cycle; idx increments; return to SCAN.
  - Dropping req[idx] mid-grant does not revoke the grant; only done ends it.
  - Timeout counter:
    - Clears on entry to GRANT and increments each GRANT cycle.
    - On reaching TMO-1 without done, force release exactly like done and pulse timeout for 1 cycle.
- Outside GRANT:
  - wr_en = 0.
  - done and wr_valid_in inputs are ignored.
- SWAP:
  - swap = 1 for exactly one cycle, then go to IDLE.
  - busy drops the cycle after SWAP.
- Frame start seen in any state other than IDLE:
  - overrun pulses for 1 cycle.
  - The frame start is otherwise ignored; the current sequence continues and no second sequence is queued.
- Frame start coinciding with the SWAP cycle:
  - Counts as overrun; the next frame start is required to start a new sequence.
- Reset mid-sequence:
  - Next cycle: grant = 0, wr_en = 0, swap = 0, and the FSM is IDLE.
  - No swap is issued for the aborted frame.
- Invariants:
  - grant is never more than one bit hot.
  - wr_en is never 1 unless grant was nonzero in the previous cycle.

Test Plan:
- Reset, then frame start with req=4'b0000 -> SCAN visits idx 0..3; swap pulses 5 cycles after leaving IDLE; wr_en stays 0; busy returns to 0.
- req=4'b0101; requester 0 writes (3,4,colour 8'h1F) for 2 cycles then asserts done; requester 2 writes 1 pixel then done -> grant 0001 then 0100; each pixel appears on draw_* with wr_en one cycle after its input; requester 1 and 3 inputs are never forwarded; swap pulses once.
- While requester 0 is granted, drive wr_valid_in[1]=1 with x=99 -> draw_x never equals 99; wr_en reflects only requester 0.
- Frame start while in GRANT -> overrun pulses 1 cycle; sequence completes normally with a single swap.
- TMO=16; requester 1 granted and never asserts done -> timeout pulses after 16 GRANT cycles; grant moves to the next requesting index.
- Assert Reset during GRANT with wr_valid_in high -> next cycle grant=0, wr_en=0, busy=0; no swap until a new frame start completes a sequence.
